// File: rtl/hicore_bjp_pipe.sv
// ---------------------------------------------------------------------------
// hicore_bjp_pipe
//
// Purpose:
//   Branch/jump execution unit for the HiCore out-of-order core.
//   - Resolves the branch condition and the target address.
//   - Computes the link value for JAL/JALR.
//   - Compares the outcome against the front-end prediction.
//   - Buffers results in a DEPTH-entry FIFO, so a stalled write-back
//     port does not stall issue.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   i_issue2bjp_valid      issue offers an op
//   i_issue2bjp_ready      unit can accept an op (FIFO not full)
//   i_issue2bjp_cancel     op is squashed: consumed, no result produced
//   bjp_op                 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU,
//                          8 JAL, 9 JALR, others illegal
//   bjp_src1, bjp_src2     register operands
//   bjp_pc, bjp_imm        instruction PC and sign-extended offset
//   bjp_pred_taken         front-end taken prediction
//   bjp_pred_target        front-end predicted target
//   bjp_rob_ptr            ROB entry of the op
//   bjp_wb_valid           FIFO head valid (suppressed during flush)
//   bjp_wb_ready           write-back arbiter grant
//   bjp_wb_ptr             ROB entry of the head result
//   bjp_wb_rd_wen          head writes rd (JAL/JALR)
//   bjp_wb_rd_data         link value pc+4, or 0 when there is no rd
//   bjp_wb_mispred         redirect required
//   bjp_wb_target          correct next PC
//   flush                  pipeline flush: clears the FIFO
// ---------------------------------------------------------------------------
module hicore_bjp_pipe #(
    parameter int XLEN  = 32,
    parameter int PTR_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_issue2bjp_valid,
    output logic             i_issue2bjp_ready,
    input  logic             i_issue2bjp_cancel,
    input  logic [3:0]       bjp_op,
    input  logic [XLEN-1:0]  bjp_src1,
    input  logic [XLEN-1:0]  bjp_src2,
    input  logic [XLEN-1:0]  bjp_pc,
    input  logic [XLEN-1:0]  bjp_imm,
    input  logic             bjp_pred_taken,
    input  logic [XLEN-1:0]  bjp_pred_target,
    input  logic [PTR_W-1:0] bjp_rob_ptr,
    output logic             bjp_wb_valid,
    input  logic             bjp_wb_ready,
    output logic [PTR_W-1:0] bjp_wb_ptr,
    output logic             bjp_wb_rd_wen,
    output logic [XLEN-1:0]  bjp_wb_rd_data,
    output logic             bjp_wb_mispred,
    output logic [XLEN-1:0]  bjp_wb_target,
    input  logic             flush
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [3:0] OP_BEQ  = 4'd0;
    localparam logic [3:0] OP_BNE  = 4'd1;
    localparam logic [3:0] OP_BLT  = 4'd2;
    localparam logic [3:0] OP_BGE  = 4'd3;
    localparam logic [3:0] OP_BLTU = 4'd4;
    localparam logic [3:0] OP_BGEU = 4'd5;
    localparam logic [3:0] OP_JAL  = 4'd8;
    localparam logic [3:0] OP_JALR = 4'd9;

    logic             taken;
    logic             is_jump;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  link;
    logic [XLEN-1:0]  next_pc;
    logic             mispred;
    logic [XLEN-1:0]  jalr_sum;

    logic [PTR_W-1:0] ptr_q     [DEPTH];
    logic             rd_wen_q  [DEPTH];
    logic [XLEN-1:0]  rd_data_q [DEPTH];
    logic             mispred_q [DEPTH];
    logic [XLEN-1:0]  target_q  [DEPTH];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Resolve the op.
    // Illegal opcodes fall into the default arm: not taken, no rd write.
    // The common mispredict formula then reduces to pred_taken.
    always_comb begin
        taken    = 1'b0;
        is_jump  = 1'b0;
        jalr_sum = bjp_src1 + bjp_imm;
        unique case (bjp_op)
            OP_BEQ:  taken = (bjp_src1 == bjp_src2);
            OP_BNE:  taken = (bjp_src1 != bjp_src2);
            OP_BLT:  taken = ($signed(bjp_src1) <  $signed(bjp_src2));
            OP_BGE:  taken = ($signed(bjp_src1) >= $signed(bjp_src2));
            OP_BLTU: taken = (bjp_src1 <  bjp_src2);
            OP_BGEU: taken = (bjp_src1 >= bjp_src2);
            OP_JAL:  begin taken = 1'b1; is_jump = 1'b1; end
            OP_JALR: begin taken = 1'b1; is_jump = 1'b1; end
            default: begin taken = 1'b0; is_jump = 1'b0; end
        endcase
        if (bjp_op == OP_JALR) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            target = bjp_pc + bjp_imm;
        end
        link    = bjp_pc + XLEN'(4);
        next_pc = taken ? target : link;
        mispred = (taken != bjp_pred_taken) |
                  (taken & (target != bjp_pred_target));
    end

    // Handshake.
    // Ready depends only on occupancy, so a full FIFO never passes an op
    // through, even when the write-back port pops in the same cycle.
    assign i_issue2bjp_ready = (count < DEPTH_C);
    assign push = i_issue2bjp_valid & i_issue2bjp_ready &
                  ~i_issue2bjp_cancel & ~flush;
    assign bjp_wb_valid = (count != '0) & ~flush;
    assign pop = bjp_wb_valid & bjp_wb_ready;

    // Write-back outputs come straight from the head entry registers.
    assign bjp_wb_ptr     = ptr_q[rd_idx];
    assign bjp_wb_rd_wen  = rd_wen_q[rd_idx];
    assign bjp_wb_rd_data = rd_data_q[rd_idx];
    assign bjp_wb_mispred = mispred_q[rd_idx];
    assign bjp_wb_target  = target_q[rd_idx];

    // FIFO storage.
    // Entries are reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ptr_q[i]     <= '0;
                rd_wen_q[i]  <= 1'b0;
                rd_data_q[i] <= '0;
                mispred_q[i] <= 1'b0;
                target_q[i]  <= '0;
            end
        end else if (push) begin
            ptr_q[wr_idx]     <= bjp_rob_ptr;
            rd_wen_q[wr_idx]  <= is_jump;
            rd_data_q[wr_idx] <= is_jump ? link : '0;
            mispred_q[wr_idx] <= mispred;
            target_q[wr_idx]  <= next_pc;
        end
    end

    // Pointers and occupancy.
    // DEPTH is a power of two, so the index counters wrap naturally.
    // Flush has priority and drops everything, including a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hicore_bjp_pipe.sv
// ---------------------------------------------------------------------------
// tb_hicore_bjp_pipe
//
// Purpose:
//   Directed self-checking bench for hicore_bjp_pipe.
//   It covers:
//   - branch and jump resolution;
//   - signed vs unsigned compares;
//   - back-pressure;
//   - cancel, flush and asynchronous reset;
//   - FIFO wrap-around under random write-back grants.
// ---------------------------------------------------------------------------
module tb_hicore_bjp_pipe;

    localparam int XLEN  = 32;
    localparam int PTR_W = 5;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             i_issue2bjp_valid;
    logic             i_issue2bjp_ready;
    logic             i_issue2bjp_cancel;
    logic [3:0]       bjp_op;
    logic [XLEN-1:0]  bjp_src1;
    logic [XLEN-1:0]  bjp_src2;
    logic [XLEN-1:0]  bjp_pc;
    logic [XLEN-1:0]  bjp_imm;
    logic             bjp_pred_taken;
    logic [XLEN-1:0]  bjp_pred_target;
    logic [PTR_W-1:0] bjp_rob_ptr;
    logic             bjp_wb_valid;
    logic             bjp_wb_ready;
    logic [PTR_W-1:0] bjp_wb_ptr;
    logic             bjp_wb_rd_wen;
    logic [XLEN-1:0]  bjp_wb_rd_data;
    logic             bjp_wb_mispred;
    logic [XLEN-1:0]  bjp_wb_target;
    logic             flush;

    int checks = 0;
    int errors = 0;

    hicore_bjp_pipe #(.XLEN(XLEN), .PTR_W(PTR_W), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_issue2bjp_valid  (i_issue2bjp_valid),
        .i_issue2bjp_ready  (i_issue2bjp_ready),
        .i_issue2bjp_cancel (i_issue2bjp_cancel),
        .bjp_op             (bjp_op),
        .bjp_src1           (bjp_src1),
        .bjp_src2           (bjp_src2),
        .bjp_pc             (bjp_pc),
        .bjp_imm            (bjp_imm),
        .bjp_pred_taken     (bjp_pred_taken),
        .bjp_pred_target    (bjp_pred_target),
        .bjp_rob_ptr        (bjp_rob_ptr),
        .bjp_wb_valid       (bjp_wb_valid),
        .bjp_wb_ready       (bjp_wb_ready),
        .bjp_wb_ptr         (bjp_wb_ptr),
        .bjp_wb_rd_wen      (bjp_wb_rd_wen),
        .bjp_wb_rd_data     (bjp_wb_rd_data),
        .bjp_wb_mispred     (bjp_wb_mispred),
        .bjp_wb_target      (bjp_wb_target),
        .flush              (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op on the issue port.
    task automatic drive_op(input logic [3:0] op, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] pc,
                            input logic [31:0] imm, input logic pt,
                            input logic [31:0] ptgt, input logic [4:0] ptr);
        i_issue2bjp_valid = 1'b1;
        bjp_op            = op;
        bjp_src1          = s1;
        bjp_src2          = s2;
        bjp_pc            = pc;
        bjp_imm           = imm;
        bjp_pred_taken    = pt;
        bjp_pred_target   = ptgt;
        bjp_rob_ptr       = ptr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_issue2bjp_valid = 1'b0; i_issue2bjp_cancel = 1'b0;
        bjp_op = '0; bjp_src1 = '0; bjp_src2 = '0; bjp_pc = '0; bjp_imm = '0;
        bjp_pred_taken = 1'b0; bjp_pred_target = '0; bjp_rob_ptr = '0;
        bjp_wb_ready = 1'b0; flush = 1'b0;
        step(); step();
        checks++;
        if (bjp_wb_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bjp_wb_valid);
        end
        checks++;
        if ({bjp_wb_ptr, bjp_wb_rd_wen, bjp_wb_rd_data, bjp_wb_mispred, bjp_wb_target} !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs: got ptr=%h rd_data=%h target=%h, expected all zero",
                               bjp_wb_ptr, bjp_wb_rd_data, bjp_wb_target);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (i_issue2bjp_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 1", i_issue2bjp_ready);
        end
    endtask

    task automatic test_beq();
        drive_op(4'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0, 5'd3);
        step();
        i_issue2bjp_valid = 1'b0;
        checks++;
        if ({bjp_wb_valid, bjp_wb_mispred, bjp_wb_rd_wen} !== 3'b110) begin
            errors++; $display("[TB] FAIL beq_flags: got valid/mispred/rd_wen=%b%b%b expected 110",
                               bjp_wb_valid, bjp_wb_mispred, bjp_wb_rd_wen);
        end
        checks++;
        if (bjp_wb_target !== 32'h120 || bjp_wb_rd_data !== 32'h0 || bjp_wb_ptr !== 5'd3) begin
            errors++; $display("[TB] FAIL beq_data: got target=%h rd=%h ptr=%0d expected 120/0/3",
                               bjp_wb_target, bjp_wb_rd_data, bjp_wb_ptr);
        end
        // Hold check: no grant, so the head must stay put.
        step();
        checks++;
        if (bjp_wb_valid !== 1'b1 || bjp_wb_target !== 32'h120) begin
            errors++; $display("[TB] FAIL beq_hold: got valid=%b target=%h expected 1/120",
                               bjp_wb_valid, bjp_wb_target);
        end
        bjp_wb_ready = 1'b1;
        step();
        bjp_wb_ready = 1'b0;
        checks++;
        if (bjp_wb_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL beq_pop: got valid=%b expected 0", bjp_wb_valid);
        end
    endtask

    task automatic test_jalr();
        drive_op(4'd9, 32'h2003, 32'h0, 32'h40, 32'h4, 1'b1, 32'h2006, 5'd7);
        step();
        i_issue2bjp_valid = 1'b0;
        checks++;
        if ({bjp_wb_valid, bjp_wb_mispred, bjp_wb_rd_wen} !== 3'b101) begin
            errors++; $display("[TB] FAIL jalr_flags: got valid/mispred/rd_wen=%b%b%b expected 101",
                               bjp_wb_valid, bjp_wb_mispred, bjp_wb_rd_wen);
        end
        checks++;
        if (bjp_wb_target !== 32'h2006 || bjp_wb_rd_data !== 32'h44 || bjp_wb_ptr !== 5'd7) begin
            errors++; $display("[TB] FAIL jalr_data: got target=%h rd=%h ptr=%0d expected 2006/44/7",
                               bjp_wb_target, bjp_wb_rd_data, bjp_wb_ptr);
        end
        bjp_wb_ready = 1'b1;
        step();
        bjp_wb_ready = 1'b0;
    endtask

    task automatic test_compare();
        drive_op(4'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0, 32'h0, 5'd1);
        step();
        drive_op(4'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b0, 32'h0, 5'd2);
        step();
        i_issue2bjp_valid = 1'b0;
        checks++;
        if (bjp_wb_ptr !== 5'd1 || bjp_wb_target !== 32'h210 || bjp_wb_mispred !== 1'b1) begin
            errors++; $display("[TB] FAIL blt_signed: got ptr=%0d target=%h mispred=%b expected 1/210/1",
                               bjp_wb_ptr, bjp_wb_target, bjp_wb_mispred);
        end
        bjp_wb_ready = 1'b1;
        step();
        bjp_wb_ready = 1'b0;
        checks++;
        if (bjp_wb_valid !== 1'b1 || bjp_wb_ptr !== 5'd2 || bjp_wb_target !== 32'h304 ||
            bjp_wb_mispred !== 1'b0) begin
            errors++; $display("[TB] FAIL bltu_unsigned: got valid=%b ptr=%0d target=%h mispred=%b expected 1/2/304/0",
                               bjp_wb_valid, bjp_wb_ptr, bjp_wb_target, bjp_wb_mispred);
        end
        bjp_wb_ready = 1'b1;
        step();
        bjp_wb_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        drive_op(4'd8, 32'h0, 32'h0, 32'h1000, 32'h40, 1'b1, 32'h1040, 5'd11);
        step();
        drive_op(4'd8, 32'h0, 32'h0, 32'h2000, 32'h40, 1'b1, 32'h2040, 5'd12);
        step();
        checks++;
        if (i_issue2bjp_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_full_ready: got %b expected 0", i_issue2bjp_ready);
        end
        // Third op is offered while full; it must be held, not accepted.
        drive_op(4'd8, 32'h0, 32'h0, 32'h3000, 32'h40, 1'b1, 32'h3040, 5'd13);
        step();
        checks++;
        if (i_issue2bjp_ready !== 1'b0 || bjp_wb_ptr !== 5'd11) begin
            errors++; $display("[TB] FAIL bp_hold: got ready=%b ptr=%0d expected 0/11",
                               i_issue2bjp_ready, bjp_wb_ptr);
        end
        bjp_wb_ready = 1'b1;
        step();
        checks++;
        if (i_issue2bjp_ready !== 1'b1 || bjp_wb_ptr !== 5'd12 || bjp_wb_rd_data !== 32'h2004) begin
            errors++; $display("[TB] FAIL bp_first_pop: got ready=%b ptr=%0d rd=%h expected 1/12/2004",
                               i_issue2bjp_ready, bjp_wb_ptr, bjp_wb_rd_data);
        end
        step();
        i_issue2bjp_valid = 1'b0;
        checks++;
        if (bjp_wb_valid !== 1'b1 || bjp_wb_ptr !== 5'd13 || bjp_wb_target !== 32'h3040) begin
            errors++; $display("[TB] FAIL bp_third: got valid=%b ptr=%0d target=%h expected 1/13/3040",
                               bjp_wb_valid, bjp_wb_ptr, bjp_wb_target);
        end
        step();
        bjp_wb_ready = 1'b0;
        checks++;
        if (bjp_wb_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_drain: got valid=%b expected 0", bjp_wb_valid);
        end
    endtask

    task automatic test_cancel();
        drive_op(4'd8, 32'h0, 32'h0, 32'h500, 32'h8, 1'b1, 32'h508, 5'd20);
        i_issue2bjp_cancel = 1'b1;
        step();
        i_issue2bjp_valid  = 1'b0;
        i_issue2bjp_cancel = 1'b0;
        bjp_wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bjp_wb_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL cancel_no_result: got valid=%b ptr=%0d expected valid 0",
                                   bjp_wb_valid, bjp_wb_ptr);
            end
            step();
        end
        bjp_wb_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive_op(4'd8, 32'h0, 32'h0, 32'h600, 32'h8, 1'b1, 32'h608, 5'd21);
        step();
        drive_op(4'd8, 32'h0, 32'h0, 32'h700, 32'h8, 1'b1, 32'h708, 5'd22);
        step();
        drive_op(4'd8, 32'h0, 32'h0, 32'h800, 32'h8, 1'b1, 32'h808, 5'd23);
        flush = 1'b1;
        bjp_wb_ready = 1'b1;
        #1;
        checks++;
        if (bjp_wb_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_cycle_valid: got %b expected 0", bjp_wb_valid);
        end
        step();
        flush = 1'b0;
        i_issue2bjp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bjp_wb_valid !== 1'b0 || i_issue2bjp_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL flush_empty: got valid=%b ready=%b ptr=%0d expected 0/1",
                                   bjp_wb_valid, i_issue2bjp_ready, bjp_wb_ptr);
            end
            step();
        end
        bjp_wb_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        drive_op(4'd8, 32'h0, 32'h0, 32'h900, 32'h8, 1'b1, 32'h908, 5'd24);
        step();
        i_issue2bjp_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bjp_wb_valid !== 1'b0 || bjp_wb_ptr !== 5'd0) begin
            errors++; $display("[TB] FAIL async_reset: got valid=%b ptr=%0d expected 0/0",
                               bjp_wb_valid, bjp_wb_ptr);
        end
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        int q[$];
        int issued;
        int received;
        int head;
        bit acc;
        bit pp;
        issued = 0;
        received = 0;
        for (int cyc = 0; cyc < 200 && received < 10; cyc++) begin
            bjp_wb_ready = 1'($urandom_range(0, 1));
            if (issued < 10) begin
                drive_op(4'd8, 32'h0, 32'h0, 32'h1000 + 32'(issued * 4), 32'h8, 1'b1,
                         32'h1008 + 32'(issued * 4), 5'(issued + 10));
            end else begin
                i_issue2bjp_valid = 1'b0;
            end
            #1;
            checks++;
            if (i_issue2bjp_ready !== (q.size() < DEPTH)) begin
                errors++; $display("[TB] FAIL wrap_ready: got %b expected %b",
                                   i_issue2bjp_ready, q.size() < DEPTH);
            end
            acc = i_issue2bjp_valid && (q.size() < DEPTH);
            pp  = (q.size() > 0) && bjp_wb_ready;
            if (pp) begin
                head = q.pop_front();
                checks++;
                if (bjp_wb_valid !== 1'b1 || bjp_wb_ptr !== 5'(head + 10) ||
                    bjp_wb_rd_data !== 32'h1004 + 32'(head * 4)) begin
                    errors++; $display("[TB] FAIL wrap_order: got valid=%b ptr=%0d rd=%h expected 1/%0d/%h",
                                       bjp_wb_valid, bjp_wb_ptr, bjp_wb_rd_data, head + 10,
                                       32'h1004 + 32'(head * 4));
                end
                received++;
            end
            if (acc) begin
                q.push_back(issued);
                issued++;
            end
            step();
        end
        i_issue2bjp_valid = 1'b0;
        bjp_wb_ready = 1'b0;
        checks++;
        if (received != 10) begin
            errors++; $display("[TB] FAIL wrap_timeout: got %0d results expected 10", received);
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_jalr();
        test_compare();
        test_back_pressure();
        test_cancel();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hicore_bjp_pipe.md
Name: hicore_bjp_pipe

Overview:
Parametrised branch/jump execution unit for the HiCore out-of-order core. It sits between the issue stage and the shared write-back arbiter.
- Resolves the branch condition and target, and computes the link value.
- Detects mispredictions against the front-end prediction.
- Holds results in a DEPTH-entry FIFO so a stalled write-back port does not stall issue.
- Supports per-op cancel and a global flush.

Parameters:
XLEN, 32, data/PC width
PTR_W, 5, ROB pointer width
DEPTH, 2, result FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
i_issue2bjp_valid  input  1  issue offers an op
i_issue2bjp_ready  output  1  unit can accept an op
i_issue2bjp_cancel  input  1  op is squashed; accept but discard
bjp_op  input  4  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 8 JAL, 9 JALR, others illegal
bjp_src1  input  XLEN  rs1 value
bjp_src2  input  XLEN  rs2 value
bjp_pc  input  XLEN  instruction PC
bjp_imm  input  XLEN  sign-extended offset
bjp_pred_taken  input  1  front-end predicted taken
bjp_pred_target  input  XLEN  front-end predicted target
bjp_rob_ptr  input  PTR_W  ROB entry
bjp_wb_valid  output  1  FIFO head valid
bjp_wb_ready  input  1  write-back arbiter grants
bjp_wb_ptr  output  PTR_W  ROB entry of head
bjp_wb_rd_wen  output  1  head writes rd (JAL/JALR)
bjp_wb_rd_data  output  XLEN  link value pc+4, 0 if no rd
bjp_wb_mispred  output  1  redirect required
bjp_wb_target  output  XLEN  correct next PC
flush  input  1  pipeline flush

Behaviour:
- Reset (asynchronous): FIFO empty, count=0, both pointers 0.
  - bjp_wb_valid=0; all other wb outputs 0.
  - i_issue2bjp_ready=1 once reset deasserts.
- Accept: an op is accepted when i_issue2bjp_valid & i_issue2bjp_ready.
- Enqueue: an accepted op is enqueued at the clock edge only if ~i_issue2bjp_cancel & ~flush. A cancelled op is consumed with no result.
- Compute (combinational on issue inputs, registered into the FIFO):
  - taken: BEQ eq; BNE ~eq; BLT/BGE signed lt / ~lt; BLTU/BGEU unsigned lt / ~lt; JAL/JALR always.
  - target: pc+imm; for JALR, (src1+imm) with bit0 cleared. All adds are modulo 2^XLEN.
  - next_pc: taken ? target : pc+4. bjp_wb_target = next_pc.
  - mispred: (taken != pred_taken) | (taken & target != pred_target).
  - rd_wen=1 only for JAL/JALR; rd_data=pc+4 there, else 0.
  - Illegal op: not taken, rd_wen=0, mispred = pred_taken.
- Latency: a result is visible on the bjp_wb_* outputs 1 cycle after acceptance (if the FIFO was empty). There is no combinational path from issue to write-back.
- Pop: occurs when bjp_wb_valid & bjp_wb_ready; the head advances at the edge.
- Outputs come straight from the FIFO head registers. While bjp_wb_valid=1 and no pop, head outputs are held stable.
- Ready: i_issue2bjp_ready = (count < DEPTH). It does not depend on bjp_wb_ready, so there is no pass-through when full.
- Simultaneous push and pop with count=DEPTH is impossible by construction.
- Simultaneous push and pop at any other count: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush:
  - In the flush cycle, bjp_wb_valid is forced to 0 and no pop occurs.
  - The FIFO is cleared at the edge; any same-cycle accept is discarded.
  - i_issue2bjp_ready follows count normally during flush.
- Asserting rst mid-operation empties the FIFO immediately.

Test Plan:
- BEQ: src1=src2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle wb_valid=1, mispred=1, target=0x120, rd_wen=0, rd_data=0.
- JALR: src1=0x2003, imm=4, pc=0x40, pred_taken=1, pred_target=0x2006 -> target=0x2006, mispred=0, rd_wen=1, rd_data=0x44.
- Signed/unsigned compare: BLT src1=0xFFFFFFFF, src2=1 -> taken. BLTU with the same operands -> not taken, target=pc+4.
- Back-pressure with bjp_wb_ready=0, DEPTH=2: two ops accepted, ready drops to 0; third op held. Raise wb_ready -> results pop in order; ready=1 the cycle after the first pop.
- Cancel/flush:
  - Cancelled op -> never appears on write-back.
  - flush with 2 entries queued plus one issuing -> wb_valid=0 that cycle, FIFO empty next cycle, no stale result ever output.
- Wrap-around: 10 back-to-back ops with random wb_ready -> output order and ROB ptrs match issue order exactly.
